// File: rtl/adc_seq_pkg.sv
// Shared definitions for the ADC sample sequencer: state encoding, default
// sample geometry and the drop-counter width.
package adc_seq_pkg;

  localparam int DefaultAdcDataWidth = 16;
  localparam int DefaultNumChannels  = 8;
  localparam int DropCountWidth      = 16;

  typedef enum logic [2:0] {
    IDLE,
    CONV,
    COLLECT,
    WRITE,
    WAIT_TICK
  } seqState_t;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [DropCountWidth-1:0] satInc(input logic [DropCountWidth-1:0] value);
    return (value == '1) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/adc_rate_tick.sv
// Sample-rate tick generator: counts a latched divider down to zero while
// running and emits a one-cycle tick every iDiv+1 cycles.
module adc_rate_tick #(
  parameter int pDivWidth = 16
) (
  input  logic                 iClk,
  input  logic                 iRstN,
  input  logic                 iRun,
  input  logic                 iLoad,
  input  logic [pDivWidth-1:0] iDiv,
  output logic                 oTick
);

  logic [pDivWidth-1:0] divLatch;
  logic [pDivWidth-1:0] tickCnt;

  // The divider is captured only on load, so later iDiv changes wait for the next start.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      divLatch <= '0;
      tickCnt  <= '0;
    end else if (iLoad) begin
      divLatch <= iDiv;
      tickCnt  <= iDiv;
    end else if (iRun) begin
      if (tickCnt == '0) begin
        tickCnt <= divLatch;
      end else begin
        tickCnt <= tickCnt - 1'b1;
      end
    end
  end

  assign oTick = iRun && (tickCnt == '0);

endmodule

// File: rtl/adc_sample_sequencer.sv
// Paces ADC conversions, assembles per-channel words into one sample and
// hands whole packets to the packer, tracking lost ticks and channel timeouts.
module adc_sample_sequencer
  import adc_seq_pkg::*;
#(
  parameter int pAdcDataWidth     = DefaultAdcDataWidth,
  parameter int pNumChannels      = DefaultNumChannels,
  parameter int pSamplesPerPacket = 15,
  parameter int pTimeoutCycles    = 255
) (
  input  logic                                  iClk,
  input  logic                                  iRstN,
  input  logic                                  iEnable,
  input  logic [15:0]                           iRateDiv,
  output logic                                  oAdcConv,
  input  logic                                  iAdcChValid,
  input  logic [pAdcDataWidth-1:0]              iAdcChData,
  output logic                                  oWrEn,
  output logic [pAdcDataWidth*pNumChannels-1:0] oAdcSampleData,
  input  logic                                  iPackerWrFull,
  input  logic                                  iClrErr,
  output logic                                  oBusy,
  output logic                                  oOverrun,
  output logic                                  oTimeout,
  output logic [DropCountWidth-1:0]             oDropCount
);

  localparam int ChIdxW  = (pNumChannels > 1) ? $clog2(pNumChannels) : 1;
  localparam int PktIdxW = (pSamplesPerPacket > 1) ? $clog2(pSamplesPerPacket) : 1;
  localparam int ToCntW  = $clog2(pTimeoutCycles + 1);

  localparam logic [ChIdxW-1:0]  LastCh  = ChIdxW'(pNumChannels - 1);
  localparam logic [PktIdxW-1:0] LastPkt = PktIdxW'(pSamplesPerPacket - 1);
  localparam logic [ToCntW-1:0]  LastTo  = ToCntW'(pTimeoutCycles - 1);

  seqState_t          state;
  seqState_t          nextState;
  logic [ChIdxW-1:0]  chIdx;
  logic [PktIdxW-1:0] pktIdx;
  logic [PktIdxW-1:0] pktIdxInc;
  logic [ToCntW-1:0]  toCnt;
  logic               tick;
  logic               tickLost;
  logic               storeWord;
  logic               wrFire;
  logic               timeoutHit;

  adc_rate_tick #(
    .pDivWidth(16)
  ) uRateTick (
    .iClk (iClk),
    .iRstN(iRstN),
    .iRun (state != IDLE),
    .iLoad((state == IDLE) && iEnable),
    .iDiv (iRateDiv),
    .oTick(tick)
  );

  assign pktIdxInc = (pktIdx == LastPkt) ? '0 : pktIdx + 1'b1;
  assign tickLost  = tick && ((state == CONV) || (state == COLLECT) || (state == WRITE));
  assign oBusy     = (state != IDLE);

  // Stopping is only allowed once the packet index is back at zero, so a
  // deasserted iEnable always drains to a packet boundary.
  always_comb begin
    nextState  = state;
    storeWord  = 1'b0;
    wrFire     = 1'b0;
    timeoutHit = 1'b0;
    case (state)
      IDLE: begin
        if (iEnable) nextState = CONV;
      end
      CONV: begin
        nextState = COLLECT;
      end
      COLLECT: begin
        if (iAdcChValid) begin
          storeWord = 1'b1;
          if (chIdx == LastCh) nextState = WRITE;
        end else if (toCnt == LastTo) begin
          timeoutHit = 1'b1;
          nextState  = (!iEnable && (pktIdx == '0)) ? IDLE : WAIT_TICK;
        end
      end
      WRITE: begin
        if (!iPackerWrFull) begin
          wrFire    = 1'b1;
          nextState = (!iEnable && (pktIdxInc == '0)) ? IDLE : WAIT_TICK;
        end
      end
      WAIT_TICK: begin
        if (tick) nextState = CONV;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state          <= IDLE;
      oAdcConv       <= 1'b0;
      oWrEn          <= 1'b0;
      oAdcSampleData <= '0;
      chIdx          <= '0;
      pktIdx         <= '0;
      toCnt          <= '0;
    end else begin
      state    <= nextState;
      oAdcConv <= (nextState == CONV);
      oWrEn    <= wrFire;
      if (wrFire) pktIdx <= pktIdxInc;
      if (state == CONV) begin
        chIdx <= '0;
        toCnt <= '0;
      end else if (storeWord) begin
        chIdx <= chIdx + 1'b1;
        toCnt <= '0;
      end else if (state == COLLECT) begin
        toCnt <= toCnt + 1'b1;
      end
      for (int k = 0; k < pNumChannels; k++) begin
        if (storeWord && (chIdx == ChIdxW'(k))) begin
          oAdcSampleData[k*pAdcDataWidth +: pAdcDataWidth] <= iAdcChData;
        end
      end
    end
  end

  // A clear in the same cycle as a lost tick is applied first, so the tick still counts.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      oOverrun   <= 1'b0;
      oTimeout   <= 1'b0;
      oDropCount <= '0;
    end else begin
      if (iClrErr) begin
        oOverrun   <= 1'b0;
        oTimeout   <= 1'b0;
        oDropCount <= '0;
      end
      if (tickLost) begin
        oOverrun   <= 1'b1;
        oDropCount <= iClrErr ? DropCountWidth'(1) : satInc(oDropCount);
      end
      if (timeoutHit) oTimeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Scoreboard bench for adc_sample_sequencer: an ADC model pushes expected
// samples, a monitor pops and compares them on every oWrEn.
module tb_adc_sample_sequencer;

  localparam int W  = 16;
  localparam int N  = 8;
  localparam int DW = W * N;

  logic          iClk;
  logic          iRstN;
  logic          iEnable;
  logic [15:0]   iRateDiv;
  logic          oAdcConv;
  logic          iAdcChValid;
  logic [W-1:0]  iAdcChData;
  logic          oWrEn;
  logic [DW-1:0] oAdcSampleData;
  logic          iPackerWrFull;
  logic          iClrErr;
  logic          oBusy;
  logic          oOverrun;
  logic          oTimeout;
  logic [15:0]   oDropCount;

  int            checks = 0;
  int            failures = 0;
  int            writeCount = 0;
  int            cycleCnt = 0;
  int            modelWords = N;
  int            sampleNum = 0;
  logic [DW-1:0] expQ[$];

  adc_sample_sequencer dut (
    .iClk          (iClk),
    .iRstN         (iRstN),
    .iEnable       (iEnable),
    .iRateDiv      (iRateDiv),
    .oAdcConv      (oAdcConv),
    .iAdcChValid   (iAdcChValid),
    .iAdcChData    (iAdcChData),
    .oWrEn         (oWrEn),
    .oAdcSampleData(oAdcSampleData),
    .iPackerWrFull (iPackerWrFull),
    .iClrErr       (iClrErr),
    .oBusy         (oBusy),
    .oOverrun      (oOverrun),
    .oTimeout      (oTimeout),
    .oDropCount    (oDropCount)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  always @(posedge iClk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic full, input logic clr);
    iEnable       = en;
    iPackerWrFull = full;
    iClrErr       = clr;
  endtask

  task automatic waitConv(input int limit, output int at);
    int k;
    k  = 0;
    at = -1;
    while (k < limit) begin
      @(negedge iClk);
      if (oAdcConv) begin
        at = cycleCnt;
        break;
      end
      k++;
    end
    if (at < 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL convWait actual=none expected=oAdcConv within %0d cycles", limit);
    end
  endtask

  task automatic waitIdle(input int limit);
    int k;
    k = 0;
    while (oBusy && (k < limit)) begin
      @(negedge iClk);
      k++;
    end
    checkOutput("idleReached", DW'(oBusy), DW'(0));
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "Conv"},    DW'(oAdcConv),   DW'(0));
    checkOutput({tag, "WrEn"},    DW'(oWrEn),      DW'(0));
    checkOutput({tag, "Busy"},    DW'(oBusy),      DW'(0));
    checkOutput({tag, "Overrun"}, DW'(oOverrun),   DW'(0));
    checkOutput({tag, "Timeout"}, DW'(oTimeout),   DW'(0));
    checkOutput({tag, "Drop"},    DW'(oDropCount), DW'(0));
    checkOutput({tag, "Data"},    oAdcSampleData,  DW'(0));
  endtask

  // ADC front-end model: answers each conversion 20 cycles later with words i+8n.
  initial begin
    int            words;
    logic [DW-1:0] expSample;
    iAdcChValid = 1'b0;
    iAdcChData  = '0;
    forever begin
      @(negedge iClk);
      if (iRstN && oAdcConv) begin
        words = modelWords;
        if (words == N) begin
          expSample = '0;
          for (int i = 0; i < N; i++) expSample[i*W +: W] = W'(i + 8 * sampleNum);
          expQ.push_back(expSample);
        end
        repeat (20) @(negedge iClk);
        for (int i = 0; i < words; i++) begin
          iAdcChValid = 1'b1;
          iAdcChData  = W'(i + 8 * sampleNum);
          @(negedge iClk);
        end
        iAdcChValid = 1'b0;
        iAdcChData  = '0;
        sampleNum++;
      end
    end
  end

  // Monitor: every packer write must match the oldest expected sample.
  initial begin
    forever begin
      @(negedge iClk);
      if (iRstN && oWrEn) begin
        writeCount++;
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpectedWrite actual=%0h expected=no write", oAdcSampleData);
        end else begin
          checkOutput("sampleData", oAdcSampleData, expQ.pop_front());
        end
      end
    end
  end

  initial begin
    repeat (20000) @(posedge iClk);
    failures++;
    $display("[TB] FAIL watchdog actual=%0d cycles expected=finish earlier", cycleCnt);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int convAt[15];
    int t;
    int tB;
    int tC;
    int wcBefore;

    iRstN    = 1'b0;
    iRateDiv = 16'd99;
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge iClk);
    checkResetOutputs("reset");
    iRstN = 1'b1;
    repeat (3) @(negedge iClk);
    checkOutput("idleAfterReset", DW'(oBusy), DW'(0));

    // Normal run, then graceful stop after three writes.
    $display("[TB] normal run and graceful stop");
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 15; k++) begin
      waitConv(250, t);
      convAt[k] = t;
      if (k > 0) checkOutput("convPeriod", DW'(convAt[k] - convAt[k-1]), DW'(100));
      if (k == 2) begin
        repeat (40) @(negedge iClk);
        checkOutput("writesBeforeStop", DW'(writeCount), DW'(3));
        applyStimulus(1'b0, 1'b0, 1'b0);
      end
    end
    waitIdle(200);
    checkOutput("packetWrites", DW'(writeCount), DW'(15));
    checkOutput("normalDrops", DW'(oDropCount), DW'(0));
    checkOutput("normalOverrun", DW'(oOverrun), DW'(0));
    repeat (300) @(negedge iClk);
    checkOutput("stoppedWrites", DW'(writeCount), DW'(15));
    checkOutput("stoppedBusy", DW'(oBusy), DW'(0));

    // Backpressure: packer full for 250 cycles from the first WRITE cycle.
    $display("[TB] backpressure");
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitConv(20, tB);
    repeat (28) @(negedge iClk);
    wcBefore = writeCount;
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (122) @(negedge iClk);
    checkOutput("heldQueue", DW'(expQ.size()), DW'(1));
    if (expQ.size() > 0) checkOutput("heldData", oAdcSampleData, expQ[0]);
    checkOutput("heldBusy", DW'(oBusy), DW'(1));
    checkOutput("dropMid", DW'(oDropCount), DW'(1));
    repeat (128) @(negedge iClk);
    checkOutput("noWriteWhileFull", DW'(writeCount - wcBefore), DW'(0));
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (12) @(negedge iClk);
    checkOutput("singleWriteAfterRelease", DW'(writeCount - wcBefore), DW'(1));
    checkOutput("backpressureDrops", DW'(oDropCount), DW'(2));
    checkOutput("backpressureOverrun", DW'(oOverrun), DW'(1));
    applyStimulus(1'b1, 1'b0, 1'b1);
    @(negedge iClk);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("clearDrops", DW'(oDropCount), DW'(0));
    checkOutput("clearOverrun", DW'(oOverrun), DW'(0));

    // Timeout: only five words arrive; clear coincides with a lost tick.
    $display("[TB] channel timeout");
    modelWords = 5;
    waitConv(50, tC);
    checkOutput("convAfterRelease", DW'(tC - tB), DW'(300));
    repeat (150) @(negedge iClk);
    checkOutput("dropInCollect", DW'(oDropCount), DW'(1));
    repeat (49) @(negedge iClk);
    applyStimulus(1'b1, 1'b0, 1'b1);
    @(negedge iClk);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("clearWithTickDrop", DW'(oDropCount), DW'(1));
    checkOutput("clearWithTickOverrun", DW'(oOverrun), DW'(1));
    repeat (79) @(negedge iClk);
    checkOutput("timeoutNotYet", DW'(oTimeout), DW'(0));
    @(negedge iClk);
    checkOutput("timeoutSet", DW'(oTimeout), DW'(1));
    checkOutput("timeoutWaitTick", DW'(oBusy), DW'(1));
    modelWords = N;
    wcBefore = writeCount;
    waitConv(50, t);
    checkOutput("convAfterTimeout", DW'(t - tC), DW'(300));
    checkOutput("noWriteForTimeout", DW'(writeCount - wcBefore), DW'(0));
    repeat (40) @(negedge iClk);
    checkOutput("writeAfterTimeout", DW'(writeCount - wcBefore), DW'(1));

    // Reset in the middle of COLLECT.
    $display("[TB] reset mid-collect");
    modelWords = 4;
    waitConv(150, t);
    repeat (22) @(negedge iClk);
    iRstN = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    @(negedge iClk);
    checkResetOutputs("midReset");
    @(negedge iClk);
    iRstN = 1'b1;
    wcBefore = writeCount;
    repeat (300) @(negedge iClk);
    checkOutput("noWriteAfterReset", DW'(writeCount - wcBefore), DW'(0));
    checkOutput("idleAfterMidReset", DW'(oBusy), DW'(0));
    modelWords = N;
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitConv(20, t);
    repeat (45) @(negedge iClk);
    checkOutput("writeAfterReenable", DW'(writeCount - wcBefore), DW'(1));
    checkOutput("queueDrained", DW'(expQ.size()), DW'(0));
    applyStimulus(1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
